// File: rtl/stream_mux_n_1.sv
// ---------------------------------------------------------------------------
// stream_mux_n_1
//
// Purpose:
//   N-to-1 valid/ready stream multiplexer with a one-word registered output
//   stage. The source channel is either chosen directly by 'sel' (MODE 0) or
//   by a round-robin arbiter over the valid channels (MODE 1).
//
// Handshake:
//   A word moves across a port on a rising clk edge where that port's valid
//   and ready are both high. The output register may load whenever it is
//   empty or its current word is being taken in the same cycle
//   (load_en = !out_valid || out_ready). This gives one word per clock when
//   downstream never stalls. out_data, out_valid and grant hold steady while
//   out_valid is high and out_ready is low.
//
// Parameters:
//   N    : number of input channels (2..16)
//   W    : data width per channel (1..64)
//   MODE : 0 = select-driven, 1 = round-robin
//
// Ports:
//   clk       : clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   in_data   : N*W packed channel data, channel k at [k*W +: W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational, at most one bit high)
//   sel       : channel select, MODE 0 only
//   out_data  : registered output word
//   out_valid : registered output valid
//   out_ready : downstream ready
//   grant     : registered index of the channel that supplied out_data
// ---------------------------------------------------------------------------
module stream_mux_n_1 #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  localparam int SW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  grant
);

  // N widened by one bit so channel indices can be range-checked and wrapped
  localparam logic [SW:0] NUM = (SW+1)'(N);

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_grant;

  logic          w_load_en;
  logic          w_found;
  logic [SW-1:0] w_choice;
  logic [W-1:0]  w_ch_data;
  logic          w_ch_valid;
  logic [N-1:0]  w_ready;
  logic          w_xfer;

  assign w_load_en = !r_out_valid || out_ready;

  // -------------------------------------------------------------------------
  // Channel choice
  // -------------------------------------------------------------------------
  if (MODE == 0) begin : g_sel
    // sel may exceed N-1 when N is not a power of two; such values choose
    // nothing, so every in_ready stays low.
    always_comb begin
      w_choice = sel;
      w_found  = ({1'b0, sel} < NUM);
    end
  end else begin : g_rr
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    // Search starts at r_ptr: the channel just after the last one served.
    logic [SW-1:0] r_ptr;
    logic [SW:0]   w_idx_sum;
    logic [SW-1:0] w_idx;

    always_comb begin
      w_found   = 1'b0;
      w_choice  = '0;
      w_idx_sum = '0;
      w_idx     = '0;
      for (int i = 0; i < N; i++) begin
        // ptr + i stays below 2N-1, so a single subtraction wraps it
        w_idx_sum = {1'b0, r_ptr} + (SW+1)'(i);
        if (w_idx_sum >= NUM) begin
          w_idx_sum = w_idx_sum - NUM;
        end
        w_idx = w_idx_sum[SW-1:0];
        if (!w_found && in_valid[w_idx]) begin
          w_found  = 1'b1;
          w_choice = w_idx;
        end
      end
    end

    // Pointer only moves on a real input transfer
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ptr <= '0;
      end else if (w_xfer) begin
        r_ptr <= (w_choice == LAST) ? '0 : w_choice + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data/valid mux and one-hot ready. Loop compare instead of a variable
  // index keeps out-of-range selects from reading past the packed bus.
  // -------------------------------------------------------------------------
  always_comb begin
    w_ch_data  = '0;
    w_ch_valid = 1'b0;
    w_ready    = '0;
    for (int k = 0; k < N; k++) begin
      if (w_choice == SW'(k)) begin
        w_ch_data  = in_data[k*W +: W];
        w_ch_valid = in_valid[k];
        // rst_n gate keeps ready low for the whole time reset is held
        if (rst_n && w_load_en && w_found) begin
          w_ready[k] = 1'b1;
        end
      end
    end
  end

  assign w_xfer = rst_n && w_load_en && w_found && w_ch_valid;

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_grant     <= '0;
    end else if (w_xfer) begin
      // Covers both the empty case and accept-and-replace in one cycle
      r_out_data  <= w_ch_data;
      r_out_valid <= 1'b1;
      r_grant     <= w_choice;
    end else if (out_ready) begin
      // Word taken with nothing to replace it; data and grant are kept
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign grant     = r_grant;

endmodule

// File: doc/stream_mux_n_1.md
STREAM_MUX_N_1 -- requirements
Module: stream_mux_n_1

Interface
REQ-001 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, in bits; legal range 1..64.
REQ-003 Parameter MODE, default 0: 0 = select-driven, 1 = round-robin arbitration.
REQ-004 Local SW = $clog2(N) SHALL size the sel and grant ports.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  N*W  channel k data is in_data[k*W +: W].
REQ-008 in_valid  input  N  per-channel valid.
REQ-009 in_ready  output  N  per-channel ready; combinational.
REQ-010 sel  input  SW  channel select; used in MODE 0, ignored in MODE 1.
REQ-011 out_data  output  W  registered output data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 grant  output  SW  registered index of the channel that supplied the current out_data.

Function
REQ-015 A transfer SHALL occur on a port when its valid and ready are both high at a rising clk edge.
REQ-016 load_en = !out_valid || out_ready; the output register SHALL accept a new word only when load_en is high.
REQ-017 At most one in_ready bit SHALL be high in any cycle, and it SHALL be high only when load_en is high.
REQ-018 MODE 0: chosen channel = sel; in_ready[sel] = load_en. If sel >= N, no channel is chosen and all in_ready bits are 0.
REQ-019 MODE 1: chosen channel = the first k with in_valid[k] = 1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-020 MODE 1: in_ready[chosen] = load_en; if no in_valid bit is high, all in_ready bits are 0.
REQ-021 MODE 1: on each input transfer from channel k, ptr SHALL become (k+1) mod N. ptr SHALL be unchanged in cycles with no input transfer.
REQ-022 On an input transfer from channel k:
  - out_data <= channel k data, out_valid <= 1, grant <= k.
  - Latency is one clock from input transfer to out_valid.
REQ-023 When out_valid is high, out_ready is high and there is no input transfer in the same cycle, out_valid SHALL go to 0.
  - out_data and grant SHALL hold their values.
REQ-024 While out_valid && !out_ready, out_data, out_valid and grant SHALL remain stable.
REQ-025 Simultaneous output accept and input transfer SHALL replace the word with no bubble, giving one word per clock sustained throughput.
REQ-026 A change of sel or in_valid while the output is stalled SHALL NOT alter the held word.
REQ-027 MODE 1 fairness: with all N channels continuously valid and out_ready = 1, grants SHALL cycle 0,1,...,N-1,0,...

Reset
REQ-028 While rst_n = 0, the block SHALL asynchronously set:
  - out_valid = 0, out_data = 0, grant = 0, ptr = 0.
  - All in_ready bits = 0 while reset is held.
REQ-029 Reset asserted mid-stall SHALL discard the held word; no transfer is reported after reset release.
REQ-030 First input transfer is possible at the first rising edge with rst_n = 1.

Verification
REQ-031 MODE 0, N=4, W=8:
  - Stimulus: in_data = {8'h44, 8'h33, 8'h22, 8'h11}, in_valid = 4'b1111, sel = 2, out_ready = 1.
  - Response: next cycle out_data = 8'h33, grant = 2, out_valid = 1; in_ready = 4'b0100.
REQ-032 Backpressure:
  - Stimulus: out_valid = 1 holding 8'h33, out_ready = 0 for 3 cycles while sel changes to 0.
  - Response: out_data stays 8'h33, in_ready = 0000; when out_ready = 1, in the next cycle out_data = 8'h11, grant = 0.
REQ-033 MODE 1 round-robin:
  - Stimulus: in_valid = 4'b1111, out_ready = 1 for 8 cycles.
  - Response: grant sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
REQ-034 MODE 1 sparse requests:
  - Stimulus: ptr = 0, in_valid = 4'b1010.
  - Response: grant 1, then 3, then 1; in_valid = 0000 gives out_valid = 0 after the last accept.
REQ-035 MODE 0, N=4, SW=2: sel is always < N, so the all-zero in_ready case of REQ-018 cannot be reached.
  - Stimulus: N=5 (SW=3), sel = 7 with all in_valid high.
  - Response: in_ready = 0, out_valid = 0 after drain.
REQ-036 Reset mid-stall:
  - Stimulus: out_valid = 1, out_ready = 0, then pulse rst_n low asynchronously between clock edges.
  - Response: out_valid = 0, grant = 0, out_data = 0 immediately; MODE 1 next grant starts from channel 0.
